// File: rtl/io_ports_if.sv
`default_nettype none
// ============================================================================
//  Module   : io_ports_if
//  Purpose  : CPU data-bus strobe/address/write-data bundle for io_ports.
//             The CPU side drives it; the I/O block listens.
//  Revision : 1.0  initial release
// ============================================================================
interface io_ports_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic                  in_write_en;
  logic                  in_read_en;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;

  modport master (
    output in_write_en,
    output in_read_en,
    output in_addr,
    output in_data
  );

  modport slave (
    input in_write_en,
    input in_read_en,
    input in_addr,
    input in_data
  );
endinterface
`default_nettype wire

// File: rtl/io_ports.sv
`default_nettype none
// ============================================================================
//  Module   : io_ports
//  Purpose  : Memory-mapped 4-bit input port (sign-extended read-back onto a
//             tri-state data bus) and 4-bit output register (write-only).
//  Revision : 1.0  initial release
// ============================================================================
module io_ports #(
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    PORT_WIDTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] INPUT_ADDR  = 10'h3FE,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_ADDR = 10'h3FF
) (
  input  wire                   clk,
  input  wire                   rst_n,
  io_ports_if.slave             bus,
  input  wire  [PORT_WIDTH-1:0] in_port,
  output logic [PORT_WIDTH-1:0] out_port,
  // Read data stays a plain net so it can be resolved as a shared tri-state bus.
  output wire  [DATA_WIDTH-1:0] out_data
);

  logic [PORT_WIDTH-1:0] in_reg;
  logic [PORT_WIDTH-1:0] r_out_port;
  logic                  w_rd_sel;
  logic                  w_wr_sel;

  // Upper write-data bits carry no meaning for a nibble-wide output port.
  wire unused_data_hi = ^bus.in_data[DATA_WIDTH-1:PORT_WIDTH];

  // Full-width address match; the two ports never share an address.
  assign w_rd_sel = bus.in_read_en  && (bus.in_addr == INPUT_ADDR);
  assign w_wr_sel = bus.in_write_en && (bus.in_addr == OUTPUT_ADDR);

  // Unconditional one-edge sample of the external input pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_reg <= '0;
    else        in_reg <= in_port;
  end

  // Output register loads only on an addressed write to the output port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_out_port <= '0;
    else if (w_wr_sel) r_out_port <= bus.in_data[PORT_WIDTH-1:0];
  end

  assign out_port = r_out_port;

  // Drive the bus only when the input port is addressed; otherwise release it.
  assign out_data = w_rd_sel
                  ? {{(DATA_WIDTH-PORT_WIDTH){in_reg[PORT_WIDTH-1]}}, in_reg}
                  : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_io_ports.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_io_ports
//  Purpose  : Self-checking bench for io_ports: directed scenarios followed by
//             randomized bus traffic compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_io_ports;
  localparam logic [9:0] IN_A  = 10'h3FE;
  localparam logic [9:0] OUT_A = 10'h3FF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_port;
  wire  [3:0] out_port;
  wire  [7:0] out_data;
  logic       cmp_en = 1'b0;

  int checks = 0;
  int errors = 0;

  io_ports_if bus ();

  io_ports dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .in_port  (in_port),
    .out_port (out_port),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  // Behavioural model: what the CPU should see as "last sampled pins" and
  // "last value written to the output address".
  logic [3:0] m_sample;
  logic [3:0] m_port;

  // Model state follows the bus rules: sample every edge, load on write to OUT_A.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sample <= 4'd0;
      m_port   <= 4'd0;
    end else begin
      m_sample <= in_port;
      if (bus.in_write_en && bus.in_addr == OUT_A) m_port <= bus.in_data[3:0];
    end
  end

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A released bus reads as Z on 4-state tools and as 0 on 2-state tools;
  // any other value means the block is driving when it should not.
  task automatic check_hiz(input string name, input logic [7:0] act);
    checks++;
    if (!(act === 8'hzz || act === 8'h00)) begin
      errors++;
      $display("FAIL %s: got %h expected zz (released) at %0t", name, act, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check4("cyc_out_port", out_port, m_port);
      if (bus.in_read_en && bus.in_addr == IN_A)
        check8("cyc_read", out_data, 8'($signed(m_sample)));
      else
        check_hiz("cyc_read_hiz", out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_port         = 4'd0;
    bus.in_write_en = 1'b0;
    bus.in_read_en  = 1'b0;
    bus.in_addr     = 10'd0;
    bus.in_data     = 8'd0;
    rst_n           = 1'b0;
    tick();
    tick();
    check4("reset_out_port", out_port, 4'b0000);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Non-matching address: bus released.
    bus.in_read_en = 1'b1;
    in_port        = 4'b1100;
    bus.in_addr    = 10'(8'h55);
    tick();
    check_hiz("t1_read_055", out_data);

    // Input port read, sign-extended, one-edge latency.
    bus.in_addr = IN_A;
    tick();
    check8("t2_read_fc", out_data, 8'b11111100);
    in_port = 4'b0001;
    #1;
    check8("t2_no_edge", out_data, 8'b11111100);
    tick();
    check8("t2_after_edge", out_data, 8'b00000001);

    // Writes: wrong address ignored, output address loads low nibble.
    bus.in_read_en  = 1'b0;
    bus.in_write_en = 1'b1;
    bus.in_data     = 8'b10001100;
    bus.in_addr     = 10'h055;
    tick();
    check4("t3_write_055", out_port, 4'b0000);
    bus.in_addr = OUT_A;
    tick();
    check4("t3_write_3ff", out_port, 4'b1100);

    // Write to input address ignored; output port not readable.
    bus.in_addr = IN_A;
    bus.in_data = 8'hFF;
    tick();
    check4("t4_write_3fe", out_port, 4'b1100);
    bus.in_write_en = 1'b0;
    bus.in_read_en  = 1'b1;
    bus.in_addr     = OUT_A;
    #1;
    check_hiz("t4_read_3ff", out_data);

    // Asynchronous reset between edges.
    in_port = 4'b0111;
    tick();
    bus.in_addr = IN_A;
    #1;
    check8("t5_pre_reset_read", out_data, 8'h07);
    rst_n = 1'b0;
    #1;
    check4("t5_reset_out_port", out_port, 4'b0000);
    check8("t5_reset_read", out_data, 8'h00);
    tick();
    rst_n = 1'b1;

    // Read and write strobes together at the output address.
    bus.in_read_en  = 1'b1;
    bus.in_write_en = 1'b1;
    bus.in_addr     = OUT_A;
    bus.in_data     = 8'h0A;
    #1;
    check_hiz("t6_read_before", out_data);
    tick();
    check4("t6_out_port", out_port, 4'b1010);
    check_hiz("t6_read_after", out_data);

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      in_port         = 4'($urandom);
      bus.in_read_en  = 1'($urandom);
      bus.in_write_en = 1'($urandom);
      bus.in_data     = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       bus.in_addr = IN_A;
        1:       bus.in_addr = OUT_A;
        2:       bus.in_addr = 10'($urandom_range(0, 255));
        default: bus.in_addr = 10'($urandom);
      endcase
      if ($urandom_range(0, 39) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check4("rnd_reset_out_port", out_port, 4'b0000);
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
